// File: rtl/io_prog_pkg.sv
// Shared types and default timing for the IO bank programming controller.
package io_prog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } prog_state_t;

  localparam int unsigned FRAME_CNT_W   = 16;

  localparam int unsigned DEF_NUM_BL    = 8;
  localparam int unsigned DEF_NUM_WL    = 8;
  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;

endpackage : io_prog_pkg

// File: rtl/wl_onehot_dec.sv
// Word-line address decoder: gated one-hot output plus an address range flag.
module wl_onehot_dec #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_WL = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [0:NUM_WL-1] onehot,
  output logic              in_range
);

  // Extra bit keeps the compare correct when NUM_WL == 2**ADDR_W.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(NUM_WL));

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_WL; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end

endmodule : wl_onehot_dec

// File: rtl/io_bank_prog_ctrl.sv
// Converts addressed configuration frames into timed BL setup / WL pulse / BL hold
// write sequences for one column of IO tiles.
module io_bank_prog_ctrl
  import io_prog_pkg::*;
#(
  parameter int unsigned NUM_BL    = DEF_NUM_BL,
  parameter int unsigned NUM_WL    = DEF_NUM_WL,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [ADDR_W-1:0]      frame_addr,
  input  logic [0:NUM_BL-1]      frame_data,
  output logic [0:NUM_BL-1]      bl,
  output logic [0:NUM_WL-1]      wl,
  output logic                   busy,
  output logic                   err_addr,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  prog_state_t              state_q, state_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic [ADDR_W-1:0]        addr_q, addr_n;
  logic [0:NUM_BL-1]        bl_n;
  logic [0:NUM_WL-1]        wl_n;
  logic                     err_n;
  logic [FRAME_CNT_W-1:0]   frame_cnt_n;
  logic [ADDR_W-1:0]        dec_addr;
  logic                     addr_ok;

  // While idle the decoder range-checks the incoming address; otherwise it drives WL.
  assign dec_addr = (state_q == IDLE) ? frame_addr : addr_q;

  wl_onehot_dec #(
    .ADDR_W (ADDR_W),
    .NUM_WL (NUM_WL)
  ) u_wl_dec (
    .addr     (dec_addr),
    .en       (state_n == PULSE),
    .onehot   (wl_n),
    .in_range (addr_ok)
  );

  // Next-state, phase counter, captured frame and status.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    addr_n      = addr_q;
    bl_n        = bl;
    err_n       = err_addr;
    frame_cnt_n = frame_cnt;

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          if (addr_ok) begin
            addr_n  = frame_addr;
            bl_n    = frame_data;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
            state_n = SETUP;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          state_n = PULSE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_n   = CNT_W'(HOLD_CYC - 1);
          state_n = HOLD;
          if (frame_cnt != {FRAME_CNT_W{1'b1}}) begin
            frame_cnt_n = frame_cnt + FRAME_CNT_W'(1);
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cnt_n   = '0;
          bl_n    = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        bl_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      bl          <= '0;
      wl          <= '0;
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      err_addr    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      addr_q      <= addr_n;
      bl          <= bl_n;
      wl          <= wl_n;
      frame_ready <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      err_addr    <= err_n;
      frame_cnt   <= frame_cnt_n;
    end
  end

endmodule : io_bank_prog_ctrl

// File: tb/tb_io_bank_prog_ctrl.sv
// Directed bench for io_bank_prog_ctrl: default timing instance plus a stretched-timing instance.
module tb_io_bank_prog_ctrl;

  logic        clk;
  logic        rst;

  logic        v1, v2;
  logic [3:0]  a1, a2;
  logic [0:7]  d1, d2;
  logic        ready1, ready2;
  logic [0:7]  bl1, bl2;
  logic [0:7]  wl1, wl2;
  logic        busy1, busy2;
  logic        err1, err2;
  logic [15:0] cnt1, cnt2;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_cnt;
  logic        exp_err;
  logic [0:7]  wl1_prev, bl1_prev, wl2_prev, bl2_prev;

  io_bank_prog_ctrl dut (
    .prog_clk    (clk),
    .pReset      (rst),
    .frame_valid (v1),
    .frame_ready (ready1),
    .frame_addr  (a1),
    .frame_data  (d1),
    .bl          (bl1),
    .wl          (wl1),
    .busy        (busy1),
    .err_addr    (err1),
    .frame_cnt   (cnt1)
  );

  io_bank_prog_ctrl #(
    .SETUP_CYC (3),
    .PULSE_CYC (4),
    .HOLD_CYC  (2)
  ) dut2 (
    .prog_clk    (clk),
    .pReset      (rst),
    .frame_valid (v2),
    .frame_ready (ready2),
    .frame_addr  (a2),
    .frame_data  (d2),
    .bl          (bl2),
    .wl          (wl2),
    .busy        (busy2),
    .err_addr    (err2),
    .frame_cnt   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Invariants watched every cycle: one-hot WL and BL frozen while WL is high.
  always @(negedge clk) begin
    chk("wl1_onehot", 32'($countones(wl1) <= 1), 32'd1);
    chk("wl2_onehot", 32'($countones(wl2) <= 1), 32'd1);
    if (wl1 != 8'h00 && wl1_prev != 8'h00) chk("bl1_stable", 32'(bl1), 32'(bl1_prev));
    if (wl2 != 8'h00 && wl2_prev != 8'h00) chk("bl2_stable", 32'(bl2), 32'(bl2_prev));
    wl1_prev = wl1;
    bl1_prev = bl1;
    wl2_prev = wl2;
    bl2_prev = bl2;
  end

  // One default-timing frame; caller sits at a negedge with dut idle.
  // With hold set, valid stays high and the inputs are scrambled while busy.
  task automatic do_frame(input logic [3:0] a, input logic [7:0] d, input bit hold);
    logic [7:0]  oh;
    logic [15:0] cnt_before;
    oh = 8'h80 >> a;
    cnt_before = exp_cnt;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    v1 = 1'b1;
    a1 = a;
    d1 = d;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          a1 = ~a;
          d1 = ~d;
        end else begin
          v1 = 1'b0;
        end
        chk("cnt_k1", 32'(cnt1), 32'(cnt_before));
      end
      chk("bl", 32'(bl1), (k < 5) ? 32'(d) : 32'd0);
      chk("wl", 32'(wl1), (k == 2 || k == 3) ? 32'(oh) : 32'd0);
      chk("ready", 32'(ready1), (k == 5) ? 32'd1 : 32'd0);
      chk("busy", 32'(busy1), (k == 5) ? 32'd0 : 32'd1);
      chk("err", 32'(err1), 32'(exp_err));
      if (k >= 4) chk("cnt", 32'(cnt1), 32'(exp_cnt));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 16'd0;
    exp_err  = 1'b0;
    wl1_prev = '0; bl1_prev = '0; wl2_prev = '0; bl2_prev = '0;
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; d1 = '0;
    v2 = 1'b0; a2 = '0; d2 = '0;

    // Reset values
    #2;
    chk("rst_bl", 32'(bl1), 32'd0);
    chk("rst_wl", 32'(wl1), 32'd0);
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame addr 3 data A5
    do_frame(4'd3, 8'hA5, 1'b0);
    chk("cnt_after_first", 32'(cnt1), 32'd1);

    // Back-to-back frames with valid held high
    for (int f = 0; f < 8; f++) begin
      do_frame(4'(f), 8'(8'h11 * (f + 1)), (f != 7));
    end
    chk("cnt_after_b2b", 32'(cnt1), 32'd9);

    // Out-of-range address consumed in one cycle
    v1 = 1'b1;
    a1 = 4'd9;
    d1 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    exp_err = 1'b1;
    chk("oor_err", 32'(err1), 32'd1);
    chk("oor_ready", 32'(ready1), 32'd1);
    chk("oor_busy", 32'(busy1), 32'd0);
    chk("oor_bl", 32'(bl1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("oor_wl", 32'(wl1), 32'd0);
      chk("oor_err_sticky", 32'(err1), 32'd1);
      chk("oor_cnt", 32'(cnt1), 32'd9);
    end
    do_frame(4'd2, 8'h3C, 1'b0);
    chk("cnt_after_oor", 32'(cnt1), 32'd10);

    // Asynchronous reset during PULSE of addr 5
    v1 = 1'b1;
    a1 = 4'd5;
    d1 = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    chk("mid_wl_before", 32'(wl1), 32'h04);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 16'd0;
    exp_err = 1'b0;
    chk("mid_rst_wl", 32'(wl1), 32'd0);
    chk("mid_rst_bl", 32'(bl1), 32'd0);
    chk("mid_rst_ready", 32'(ready1), 32'd1);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_err", 32'(err1), 32'd0);
    chk("mid_rst_cnt", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_wl", 32'(wl1), 32'd0);
      chk("post_rst_cnt", 32'(cnt1), 32'd0);
      chk("post_rst_ready", 32'(ready1), 32'd1);
    end

    // Saturation of frame_cnt
    force dut.frame_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt;
    #1;
    chk("sat_preload", 32'(cnt1), 32'h0000FFFE);
    exp_cnt = 16'hFFFE;
    do_frame(4'd1, 8'h0F, 1'b0);
    chk("sat_1", 32'(cnt1), 32'h0000FFFF);
    do_frame(4'd4, 8'hF0, 1'b0);
    chk("sat_2", 32'(cnt1), 32'h0000FFFF);
    do_frame(4'd7, 8'h81, 1'b0);
    chk("sat_3", 32'(cnt1), 32'h0000FFFF);

    // Stretched timing: SETUP 3, PULSE 4, HOLD 2, addr 6 data 5A
    v2 = 1'b1;
    a2 = 4'd6;
    d2 = 8'h5A;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) v2 = 1'b0;
      chk("t2_bl", 32'(bl2), (k <= 9) ? 32'h5A : 32'd0);
      chk("t2_wl", 32'(wl2), (k >= 4 && k <= 7) ? 32'h02 : 32'd0);
      chk("t2_ready", 32'(ready2), (k == 10) ? 32'd1 : 32'd0);
    end
    chk("t2_cnt", 32'(cnt2), 32'd1);
    chk("t2_err", 32'(err2), 32'd0);
    chk("t2_busy", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_io_bank_prog_ctrl
